// File: rtl/seq_8bit_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier around one simple_8bit_adder.
// Optional macro SEQ_MUL_ZERO_SKIP_EN: zero operands finish in one cycle.

module simple_8bit_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c_in,
   output logic [7:0] s,
   output logic       c_out
);

   assign {c_out, s} = {1'b0, a} + {1'b0, b} + {8'b0, c_in};

endmodule

module seq_8bit_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] p
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [7:0]  m;
   logic [7:0]  acc;
   logic [7:0]  q;
   logic [3:0]  cnt;
   logic [7:0]  sum;
   logic        carry;
   logic [7:0]  next_acc;
   logic [7:0]  next_q;

   simple_8bit_adder adder (
      .a     (acc),
      .b     (m),
      .c_in  (1'b0),
      .s     (sum),
      .c_out (carry)
   );

   // One shift-and-add step: add the multiplicand only when the current multiplier bit is set.
   always_comb begin
      next_acc = acc;
      next_q   = q;
      if (q[0])
         {next_acc, next_q} = {carry, sum, q[7:1]};
      else
         {next_acc, next_q} = {1'b0, acc, q[7:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         p     <= 16'h0000;
         m     <= 8'h00;
         acc   <= 8'h00;
         q     <= 8'h00;
         cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  m   <= a;
                  acc <= 8'h00;
                  q   <= b;
                  cnt <= 4'd0;
`ifdef SEQ_MUL_ZERO_SKIP_EN
                  if (a == 8'h00 || b == 8'h00) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     p     <= 16'h0000;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
`else
                  state <= RUN;
                  busy  <= 1'b1;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc <= next_acc;
               q   <= next_q;
               cnt <= cnt + 4'd1;
               // The eighth step writes the product straight from the step result.
               if (cnt == 4'd7) begin
                  p     <= {next_acc, next_q};
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_8bit_multiplier.sv
// Self-checking bench for seq_8bit_multiplier: vector table plus hand-written
// sequences for ignored start, mid-run reset and back-to-back operation.

module tb_seq_8bit_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] p;

   int total;
   int bad;

   typedef struct {
      logic [7:0]  av;
      logic [7:0]  bv;
      logic [15:0] expP;
      int          expLat;
      int          expBusy;
   } vec_t;

   seq_8bit_multiplier dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Starts at a negedge with start set; counts negedges until done, optionally injecting a start at E3.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input bit inject,
                                output int lat, output int busyCnt, output int overlap);
      a = av;
      b = bv;
      start = 1'b1;
      lat = -1;
      busyCnt = 0;
      overlap = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (inject && k == 3) begin
            start = 1'b1;
            a = 8'h10;
            b = 8'h10;
         end
         if (inject && k == 4) start = 1'b0;
         if (busy) busyCnt++;
         if (busy && done) overlap++;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      vec_t vecs[7];
      int lat, busyCnt, overlap;
      int zl, zb;
      logic [15:0] heldP;
      bit sawDone;

      total = 0;
      bad = 0;
`ifdef SEQ_MUL_ZERO_SKIP_EN
      zl = 1;
      zb = 0;
`else
      zl = 9;
      zb = 8;
`endif
      vecs[0] = '{8'h0A, 8'h05, 16'h0032, 9, 8};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 9, 8};
      vecs[2] = '{8'h00, 8'h37, 16'h0000, zl, zb};
      vecs[3] = '{8'h37, 8'h00, 16'h0000, zl, zb};
      vecs[4] = '{8'h01, 8'hFF, 16'h00FF, 9, 8};
      vecs[5] = '{8'h80, 8'h80, 16'h4000, 9, 8};
      vecs[6] = '{8'hC8, 8'h02, 16'h0190, 9, 8};

      rst = 1'b1;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_p", {16'b0, p}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].av, vecs[i].bv, 1'b0, lat, busyCnt, overlap);
         checkOutput($sformatf("vec%0d_p", i), {16'b0, p}, {16'b0, vecs[i].expP});
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
         checkOutput($sformatf("vec%0d_busy_cycles", i), busyCnt, vecs[i].expBusy);
         checkOutput($sformatf("vec%0d_busy_done_overlap", i), overlap, 0);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
         checkOutput($sformatf("vec%0d_p_held", i), {16'b0, p}, {16'b0, vecs[i].expP});
      end

      // start during RUN must not disturb the operation in flight
      applyStimulus(8'h03, 8'h04, 1'b1, lat, busyCnt, overlap);
      checkOutput("ignore_start_p", {16'b0, p}, 32'h000C);
      checkOutput("ignore_start_latency", lat, 9);
      @(negedge clk);
      checkOutput("ignore_start_idle", {31'b0, busy}, 32'd0);

      // Reset mid-run: outputs clear asynchronously and no done follows
      heldP = p;
      checkOutput("pre_reset_p_nonzero", {31'b0, (heldP != 16'h0)}, 32'd1);
      a = 8'hC8;
      b = 8'h02;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("async_reset_done", {31'b0, done}, 32'd0);
      checkOutput("async_reset_p", {16'b0, p}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sawDone = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) sawDone = 1'b1;
      end
      checkOutput("no_done_after_reset", {31'b0, sawDone}, 32'd0);
      applyStimulus(8'h07, 8'h06, 1'b0, lat, busyCnt, overlap);
      checkOutput("after_reset_p", {16'b0, p}, 32'h002A);
      checkOutput("after_reset_latency", lat, 9);
      @(negedge clk);

      // Back-to-back: start held, second operands presented in the DONE cycle
      a = 8'h02;
      b = 8'h03;
      start = 1'b1;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      checkOutput("b2b_first_latency", lat, 9);
      checkOutput("b2b_first_p", {16'b0, p}, 32'h0006);
      a = 8'h05;
      b = 8'h05;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_busy_rises", {31'b0, busy}, 32'd1);
      checkOutput("b2b_done_dropped", {31'b0, done}, 32'd0);
      lat = -1;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      checkOutput("b2b_second_latency", lat, 9);
      checkOutput("b2b_second_p", {16'b0, p}, 32'h0019);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
